// File: rtl/gact_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : gact_scheduler
//  Function : Dispatches tagged tile requests to NUM_ENGINES GACT engines with
//             a round-robin dispatch pointer, collects finished tiles with a
//             round-robin collection pointer and returns them in completion
//             order on a registered valid/ready response port.
//  Option   : define GACT_SCHED_PERF_EN to add 32-bit wrapping dispatch and
//             completion counters (perf_dispatched / perf_completed).
//  Revision : 1.0 - initial release
// ============================================================================
module gact_scheduler #(
  parameter int NUM_ENGINES      = 4,
  parameter int REQUEST_ID_WIDTH = 16,
  parameter int PE_WIDTH         = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [REQUEST_ID_WIDTH-1:0]       req_id,
  input  logic [NUM_ENGINES-1:0]            eng_ready,
  input  logic [NUM_ENGINES-1:0]            eng_done,
  input  logic [NUM_ENGINES*PE_WIDTH-1:0]   eng_score,
  output logic [NUM_ENGINES-1:0]            eng_start,
  output logic [NUM_ENGINES-1:0]            eng_clear_done,
  output logic [REQUEST_ID_WIDTH-1:0]       eng_req_id,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [REQUEST_ID_WIDTH-1:0]       rsp_id,
  output logic [$clog2(NUM_ENGINES)-1:0]    rsp_engine,
  output logic [PE_WIDTH-1:0]               rsp_score
`ifdef GACT_SCHED_PERF_EN
  ,
  output logic [31:0]                       perf_dispatched,
  output logic [31:0]                       perf_completed
`endif
);

  localparam int EW = $clog2(NUM_ENGINES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_BUSY      = 3'd2,
    S_DONE_PEND = 3'd3,
    S_CLEAR     = 3'd4
  } slot_t;

  // Per-engine slot state, stored tag and captured score
  slot_t                       slot_q  [NUM_ENGINES];
  slot_t                       slot_d  [NUM_ENGINES];
  logic [REQUEST_ID_WIDTH-1:0] tag_q   [NUM_ENGINES];
  logic [REQUEST_ID_WIDTH-1:0] tag_d   [NUM_ENGINES];
  logic [PE_WIDTH-1:0]         score_q [NUM_ENGINES];
  logic [PE_WIDTH-1:0]         score_d [NUM_ENGINES];

  // Round-robin pointers
  logic [EW-1:0] dp_q, dp_d;
  logic [EW-1:0] cp_q, cp_d;

  // Registered response port
  logic                        rsp_valid_q,  rsp_valid_d;
  logic [REQUEST_ID_WIDTH-1:0] rsp_id_q,     rsp_id_d;
  logic [EW-1:0]               rsp_engine_q, rsp_engine_d;
  logic [PE_WIDTH-1:0]         rsp_score_q,  rsp_score_d;

  logic [NUM_ENGINES-1:0] free_vec;
  logic [NUM_ENGINES-1:0] pend_vec;
  logic [EW:0]            disp_pick;
  logic [EW:0]            col_pick;
  logic                   disp_fire;
  logic                   rsp_fire;
  logic [EW-1:0]          disp_sel;
  logic [EW-1:0]          col_sel;

  // First set bit of vec at or after ptr, wrapping; MSB of result = found.
  // Scanning from the far end down lets the nearest candidate win last.
  function automatic logic [EW:0] rr_pick(input logic [NUM_ENGINES-1:0] vec,
                                          input logic [EW-1:0]          ptr);
    logic [EW:0] pick;
    logic [EW:0] idx;
    pick = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (EW+1)'(i);
      if (idx >= (EW+1)'(NUM_ENGINES)) idx = idx - (EW+1)'(NUM_ENGINES);
      if (vec[idx[EW-1:0]]) pick = {1'b1, idx[EW-1:0]};
    end
    return pick;
  endfunction

  // Increment modulo NUM_ENGINES (NUM_ENGINES need not be a power of two)
  function automatic logic [EW-1:0] ptr_next(input logic [EW-1:0] p);
    return (p == EW'(NUM_ENGINES - 1)) ? '0 : p + EW'(1);
  endfunction

  // Slot status decode and Moore-style engine strobes
  for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_slot_flags
    assign free_vec[k]       = (slot_q[k] == S_IDLE) && eng_ready[k];
    assign pend_vec[k]       = (slot_q[k] == S_DONE_PEND);
    assign eng_start[k]      = (slot_q[k] == S_START);
    assign eng_clear_done[k] = (slot_q[k] == S_CLEAR);
  end

  assign req_ready = |free_vec;
  assign disp_pick = rr_pick(free_vec, dp_q);
  assign col_pick  = rr_pick(pend_vec, cp_q);
  assign disp_sel  = disp_pick[EW-1:0];
  assign col_sel   = col_pick[EW-1:0];
  assign disp_fire = req_valid && req_ready;
  assign rsp_fire  = rsp_valid_q && rsp_ready;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_engine = rsp_engine_q;
  assign rsp_score  = rsp_score_q;

  // Tag alongside eng_start: only one slot can be in START in any cycle
  always_comb begin
    eng_req_id = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (slot_q[k] == S_START) eng_req_id = eng_req_id | tag_q[k];
    end
  end

  // Slot next-state: dispatch enters from IDLE, collection leaves DONE_PEND
  always_comb begin
    for (int k = 0; k < NUM_ENGINES; k++) begin
      slot_d[k]  = slot_q[k];
      tag_d[k]   = tag_q[k];
      score_d[k] = score_q[k];
      case (slot_q[k])
        S_IDLE: begin
          if (disp_fire && (disp_sel == EW'(k))) begin
            slot_d[k] = S_START;
            tag_d[k]  = req_id;
          end
        end
        S_START: slot_d[k] = S_BUSY;
        S_BUSY: begin
          if (eng_done[k]) begin
            slot_d[k]  = S_DONE_PEND;
            score_d[k] = eng_score[k*PE_WIDTH +: PE_WIDTH];
          end
        end
        S_DONE_PEND: begin
          if (rsp_fire && (rsp_engine_q == EW'(k))) slot_d[k] = S_CLEAR;
        end
        S_CLEAR: slot_d[k] = S_IDLE;
        default: slot_d[k] = S_IDLE;
      endcase
    end
  end

  // Slot state, tag and score registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ENGINES; k++) begin
        slot_q[k]  <= S_IDLE;
        tag_q[k]   <= '0;
        score_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_ENGINES; k++) begin
        slot_q[k]  <= slot_d[k];
        tag_q[k]   <= tag_d[k];
        score_q[k] <= score_d[k];
      end
    end
  end

  // Pointer updates and response presentation; a new candidate is only
  // loaded while nothing is presented, so the cycle after a handshake is idle
  always_comb begin
    dp_d         = dp_q;
    cp_d         = cp_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_engine_d = rsp_engine_q;
    rsp_score_d  = rsp_score_q;
    if (disp_fire) dp_d = ptr_next(disp_sel);
    if (rsp_fire) begin
      rsp_valid_d = 1'b0;
      cp_d        = ptr_next(rsp_engine_q);
    end else if (!rsp_valid_q && col_pick[EW]) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = tag_q[col_sel];
      rsp_engine_d = col_sel;
      rsp_score_d  = score_q[col_sel];
    end
  end

  // Pointer and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q         <= '0;
      cp_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_engine_q <= '0;
      rsp_score_q  <= '0;
    end else begin
      dp_q         <= dp_d;
      cp_q         <= cp_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_engine_q <= rsp_engine_d;
      rsp_score_q  <= rsp_score_d;
    end
  end

`ifdef GACT_SCHED_PERF_EN
  logic [31:0] perf_disp_q, perf_disp_d;
  logic [31:0] perf_comp_q, perf_comp_d;

  // Wrapping handshake counters
  always_comb begin
    perf_disp_d = perf_disp_q;
    perf_comp_d = perf_comp_q;
    if (disp_fire) perf_disp_d = perf_disp_q + 32'd1;
    if (rsp_fire)  perf_comp_d = perf_comp_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_disp_q <= '0;
      perf_comp_q <= '0;
    end else begin
      perf_disp_q <= perf_disp_d;
      perf_comp_q <= perf_comp_d;
    end
  end

  assign perf_dispatched = perf_disp_q;
  assign perf_completed  = perf_comp_q;
`endif

endmodule
`default_nettype wire

// File: doc/gact_scheduler.md
GACT_SCHEDULER -- requirements
Module: gact_scheduler

Interface
REQ-001 Parameter NUM_ENGINES, default 4, number of GACT tile engines served; range 2..16.
REQ-002 Parameter REQUEST_ID_WIDTH, default 16, width of the request tag.
REQ-003 Parameter PE_WIDTH, default 16, width of the tile score.
REQ-004 Port clk  input  1  single clock; all logic on the rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req_valid / req_ready  input / output  1 / 1  tile request handshake.
REQ-007 Port req_id  input  REQUEST_ID_WIDTH  tag of the offered request.
REQ-008 Port eng_ready  input  NUM_ENGINES  per-engine ready indication.
REQ-009 Port eng_done  input  NUM_ENGINES  per-engine done level.
REQ-010 Port eng_score  input  NUM_ENGINES*PE_WIDTH  per-engine tile_score; engine k occupies bits [k*PE_WIDTH +: PE_WIDTH].
REQ-011 Port eng_start / eng_clear_done  output  NUM_ENGINES  one-hot, single-cycle pulses.
REQ-012 Port eng_req_id  output  REQUEST_ID_WIDTH  tag driven alongside eng_start.
REQ-013 Port rsp_valid / rsp_ready  output / input  1 / 1  result handshake.
REQ-014 Port rsp_id, rsp_engine, rsp_score  output  REQUEST_ID_WIDTH, clog2(NUM_ENGINES), PE_WIDTH  result payload.

Function
REQ-015 Each engine k has a slot FSM: IDLE -> START -> BUSY -> DONE_PEND -> CLEAR -> IDLE.
REQ-016 Engine k is free when its slot is IDLE and eng_ready[k]==1.
REQ-017 req_ready is combinational and equals 1 when any engine is free.
REQ-018 On a request handshake (req_valid && req_ready), the round-robin dispatch arbiter selects the free engine at or after dispatch pointer dp; that engine moves IDLE->START, its req_id is stored, and dp becomes selected+1 modulo NUM_ENGINES.
REQ-019 In START, eng_start[k]=1 and eng_req_id=stored tag for exactly one cycle; the next cycle the slot is BUSY.
REQ-020 In BUSY, eng_done[k]==1 moves the slot to DONE_PEND and captures eng_score[k].
REQ-021 rsp_valid is registered and presents one DONE_PEND engine chosen by round-robin collection pointer cp; payload is held stable until rsp_ready.
REQ-022 On a response handshake, the presented slot moves to CLEAR, cp becomes engine+1 modulo NUM_ENGINES, and a new candidate may be presented no earlier than the following cycle.
REQ-023 In CLEAR, eng_clear_done[k]=1 for one cycle; the slot then returns to IDLE.
REQ-024 Dispatch and collection proceed in the same cycle for different engines; one slot is never both dispatched and collected in one cycle.
REQ-025 At most one dispatch and one response occur per cycle; response order is completion order, not request order.
REQ-026 When all engines are busy, req_ready=0; a request held with req_valid=1 is dispatched on the first cycle an engine becomes free.

Reset
REQ-027 On rst, all slots go to IDLE, dp=cp=0, and req_ready follows eng_ready.
REQ-028 On rst, all of the following are 0: rsp_valid, rsp_id, rsp_engine, rsp_score, eng_start, eng_clear_done, eng_req_id.
REQ-029 A reset asserted mid-operation discards all in-flight tags without a response; engines are reset by their own reset.

Configuration
REQ-030 With GACT_SCHED_PERF_EN defined, the block adds outputs perf_dispatched and perf_completed (32 bits each, wrapping). They increment on the request handshake and the response handshake respectively, and clear on rst.
REQ-031 Without GACT_SCHED_PERF_EN, these ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-032 Reset, then all eng_ready=1 and req_id 0xA1,0xA2,0xA3 back-to-back -> eng_start pulses engines 0,1,2 on consecutive cycles with matching eng_req_id.
REQ-033 Engine 2 raises eng_done before engine 0 -> rsp order 0xA3 (rsp_engine=2) then 0xA1; each eng_clear_done pulses once, one cycle after its handshake.
REQ-034 NUM_ENGINES=4, all busy, req_valid held with req_id 0x55 -> req_ready=0; after engine 1 completes and clears -> 0x55 is dispatched to engine 1.
REQ-035 Two engines in DONE_PEND, rsp_ready=0 for 10 cycles -> rsp payload is stable throughout; then rsp_ready=1 -> both are delivered on consecutive handshakes in round-robin order.
REQ-036 rst asserted while 3 engines are BUSY -> all outputs are 0 in the same cycle; no stale response after release.
REQ-037 With GACT_SCHED_PERF_EN: 5 requests and 5 responses -> perf_dispatched=5 and perf_completed=5.
